// File: rtl/mem_wb.sv
// MEM/WB pipeline register with a multi-cycle load sequencer and stall request.
// Optional stall-cycle counter on stall_cnt_o is enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb #(
    parameter int unsigned LOAD_WAIT = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        load_i,
    input  logic        flush_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        stall_req_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LOAD_WAIT == 0) ? '0 : CNT_W'(LOAD_WAIT - 1);
    localparam logic LOAD_STALLS = (LOAD_WAIT != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            we_nxt;
    logic [AW-1:0]   waddr_nxt;
    logic [DW-1:0]   wdata_nxt;

    // Stall request: load entering, or wait counter still running; flush and reset squash it.
    always_comb begin
        stall_req_o = 1'b0;
        if (rst && !flush_i) begin
            if (state == S_IDLE)
                stall_req_o = load_i && LOAD_STALLS;
            else
                stall_req_o = (cnt != '0);
        end
    end

    // Next-state and write-back capture.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = wb_we_o;
        waddr_nxt = wb_waddr_o;
        wdata_nxt = wb_wdata_o;
        if (flush_i) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            we_nxt    = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load_i && LOAD_STALLS) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                        we_nxt    = 1'b0;
                    end else begin
                        we_nxt    = we_i && (waddr_i != '0);
                        waddr_nxt = waddr_i;
                        wdata_nxt = wdata_i;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                        we_nxt  = 1'b0;
                    end else begin
                        // Load data is valid now; load_i still refers to the same instruction.
                        state_nxt = S_IDLE;
                        we_nxt    = we_i && (waddr_i != '0);
                        waddr_nxt = waddr_i;
                        wdata_nxt = wdata_i;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    we_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wb_we_o    <= we_nxt;
            wb_waddr_o <= waddr_nxt;
            wb_wdata_o <= wdata_nxt;
        end
    end

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Free-running stall-cycle counter; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall_req_o)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: three instances with LOAD_WAIT = 1, 2 and 3.
module tb_mem_wb;

    logic        clk;
    logic        rst_n;
    logic        we    [3];
    logic [4:0]  waddr [3];
    logic [31:0] wdata [3];
    logic        load  [3];
    logic        flush [3];
    logic        wb_we    [3];
    logic [4:0]  wb_waddr [3];
    logic [31:0] wb_wdata [3];
    logic        stall    [3];
    logic [31:0] scnt     [3];

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_scnt;

    mem_wb #(.LOAD_WAIT(1), .CNT_W(4)) u_lw1 (
        .clk(clk), .rst(rst_n), .we_i(we[0]), .waddr_i(waddr[0]), .wdata_i(wdata[0]),
        .load_i(load[0]), .flush_i(flush[0]), .wb_we_o(wb_we[0]), .wb_waddr_o(wb_waddr[0]),
        .wb_wdata_o(wb_wdata[0]), .stall_req_o(stall[0]), .stall_cnt_o(scnt[0]));

    mem_wb #(.LOAD_WAIT(2), .CNT_W(4)) u_lw2 (
        .clk(clk), .rst(rst_n), .we_i(we[1]), .waddr_i(waddr[1]), .wdata_i(wdata[1]),
        .load_i(load[1]), .flush_i(flush[1]), .wb_we_o(wb_we[1]), .wb_waddr_o(wb_waddr[1]),
        .wb_wdata_o(wb_wdata[1]), .stall_req_o(stall[1]), .stall_cnt_o(scnt[1]));

    mem_wb #(.LOAD_WAIT(3), .CNT_W(4)) u_lw3 (
        .clk(clk), .rst(rst_n), .we_i(we[2]), .waddr_i(waddr[2]), .wdata_i(wdata[2]),
        .load_i(load[2]), .flush_i(flush[2]), .wb_we_o(wb_we[2]), .wb_waddr_o(wb_waddr[2]),
        .wb_wdata_o(wb_wdata[2]), .stall_req_o(stall[2]), .stall_cnt_o(scnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic ld, input logic fl);
        we[k] = w; waddr[k] = a; wdata[k] = d; load[k] = ld; flush[k] = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            we[k] = 1'b0; waddr[k] = '0; wdata[k] = '0; load[k] = 1'b0; flush[k] = 1'b0;
        end
        // Reset state; a load under reset must not request a stall.
        drive(2, 1'b1, 5'd7, 32'h1, 1'b1, 1'b0);
        tick();
        chk("rst_we",    32'(wb_we[0]), 32'd0);
        chk("rst_waddr", 32'(wb_waddr[0]), 32'd0);
        chk("rst_wdata", wb_wdata[0], 32'd0);
        chk("rst_stall", 32'(stall[2]), 32'd0);
        chk("rst_scnt",  scnt[2], 32'd0);
        drive(2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Plain capture, LOAD_WAIT=1 instance.
        tick();
        drive(0, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0);
        chk("cap_stall", 32'(stall[0]), 32'd0);
        tick();
        chk("cap_we",    32'(wb_we[0]), 32'd1);
        chk("cap_waddr", 32'(wb_waddr[0]), 32'd5);
        chk("cap_wdata", wb_wdata[0], 32'h12345678);

        // LOAD_WAIT=1 load: stall in N only, bubble in N+1, data in N+2.
        drive(0, 1'b1, 5'd3, 32'h0, 1'b1, 1'b0);
        chk("lw1_stall_n", 32'(stall[0]), 32'd1);
        tick();
        drive(0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("lw1_stall_n1", 32'(stall[0]), 32'd0);
        chk("lw1_bubble",   32'(wb_we[0]), 32'd0);
        chk("lw1_hold_a",   32'(wb_waddr[0]), 32'd5);
        tick();
        drive(0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("lw1_we",    32'(wb_we[0]), 32'd1);
        chk("lw1_waddr", 32'(wb_waddr[0]), 32'd3);
        chk("lw1_wdata", wb_wdata[0], 32'hDEADBEEF);
        chk("lw1_stall_n2", 32'(stall[0]), 32'd0);

        // Register zero suppresses the write but still loads address/data.
        drive(0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("r0_we",    32'(wb_we[0]), 32'd0);
        chk("r0_wdata", wb_wdata[0], 32'hFFFFFFFF);

        // LOAD_WAIT=3 load: stall N..N+2, result in N+4.
        drive(2, 1'b1, 5'd7, 32'h0, 1'b1, 1'b0);
        chk("lw3_stall_n", 32'(stall[2]), 32'd1);
        tick();
        chk("lw3_stall_n1", 32'(stall[2]), 32'd1);
        chk("lw3_bubble",   32'(wb_we[2]), 32'd0);
        tick();
        chk("lw3_stall_n2", 32'(stall[2]), 32'd1);
        tick();
        drive(2, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("lw3_stall_n3", 32'(stall[2]), 32'd0);
        chk("lw3_we_n3",    32'(wb_we[2]), 32'd0);
        tick();
        drive(2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("lw3_we",    32'(wb_we[2]), 32'd1);
        chk("lw3_waddr", 32'(wb_waddr[2]), 32'd7);
        chk("lw3_wdata", wb_wdata[2], 32'hCAFEF00D);
`ifdef MEM_WB_STALL_CNT_EN
        exp_scnt = 32'd3;
`else
        exp_scnt = 32'd0;
`endif
        chk("lw3_scnt", scnt[2], exp_scnt);

        // LOAD_WAIT=2 load aborted by flush in N+1.
        drive(1, 1'b1, 5'd9, 32'h11111111, 1'b1, 1'b0);
        chk("fl_stall_n", 32'(stall[1]), 32'd1);
        tick();
        drive(1, 1'b1, 5'd9, 32'h11111111, 1'b1, 1'b1);
        chk("fl_stall_n1", 32'(stall[1]), 32'd0);
        tick();
        drive(1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("fl_idle_stall", 32'(stall[1]), 32'd0);
        chk("fl_we",         32'(wb_we[1]), 32'd0);
        tick();
        chk("fl_we_after",   32'(wb_we[1]), 32'd0);

        // Flush coincident with a load in IDLE: no stall, no WAIT entry.
        drive(1, 1'b1, 5'd9, 32'h22222222, 1'b1, 1'b1);
        chk("flc_stall", 32'(stall[1]), 32'd0);
        tick();
        drive(1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("flc_idle_stall", 32'(stall[1]), 32'd0);
        chk("flc_we",         32'(wb_we[1]), 32'd0);

        // Reset mid-WAIT on the LOAD_WAIT=2 instance.
        drive(1, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 1'b0);
        tick();
        chk("pre_we", 32'(wb_we[1]), 32'd1);
        drive(1, 1'b1, 5'd6, 32'h0, 1'b1, 1'b0);
        chk("mr_stall_n", 32'(stall[1]), 32'd1);
        tick();
        chk("mr_stall_n1", 32'(stall[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_stall_drop", 32'(stall[1]), 32'd0);
        chk("mr_we",    32'(wb_we[1]), 32'd0);
        chk("mr_waddr", 32'(wb_waddr[1]), 32'd0);
        chk("mr_wdata", wb_wdata[1], 32'd0);
        drive(1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Next load after release stalls a full 2 cycles.
        drive(1, 1'b1, 5'd6, 32'h0, 1'b1, 1'b0);
        chk("post_stall_n", 32'(stall[1]), 32'd1);
        tick();
        chk("post_stall_n1", 32'(stall[1]), 32'd1);
        tick();
        drive(1, 1'b1, 5'd6, 32'h0BADCAFE, 1'b1, 1'b0);
        chk("post_stall_n2", 32'(stall[1]), 32'd0);
        tick();
        drive(1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("post_we",    32'(wb_we[1]), 32'd1);
        chk("post_waddr", 32'(wb_waddr[1]), 32'd6);
        chk("post_wdata", wb_wdata[1], 32'h0BADCAFE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
